// File: rtl/mux_n_arb.sv
// Registered N-input selector, explicit-select or round-robin; 1 clk from input transfer to out_valid.
// Backpressure: all in_ready drop while the output register holds a beat that out_ready has not taken.
module mux_n_arb #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = 3
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        select,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_chan,
   output logic                    out_valid,
   input  logic                    out_ready
);

   if (NUM_IN < 2 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
      $error("mux_n_arb: NUM_IN must lie in 2..2**SEL_W");
   end

   logic [SEL_W-1:0]  rr_ptr;
   logic              can_accept;
   logic              ex_valid;
   logic              any_valid;
   logic              hi_valid;
   logic [SEL_W-1:0]  lo_idx;
   logic [SEL_W-1:0]  hi_idx;
   logic [NUM_IN-1:0] hi_req;
   logic              grant_valid;
   logic [SEL_W-1:0]  grant;
   logic [WIDTH-1:0]  grant_data;
   logic              transfer;

   assign can_accept = !out_valid || out_ready;

   // Out-of-range select never matches a channel, so it yields no grant.
   always_comb begin
      ex_valid = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (select == SEL_W'(i)) ex_valid = in_valid[i];
      end
   end

   // Round-robin: lowest requester at or above rr_ptr, else lowest requester overall (wrap).
   always_comb begin
      hi_req    = '0;
      any_valid = 1'b0;
      hi_valid  = 1'b0;
      lo_idx    = '0;
      hi_idx    = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         hi_req[i] = in_valid[i] && (SEL_W'(i) >= rr_ptr);
      end
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            any_valid = 1'b1;
            lo_idx    = SEL_W'(i);
         end
         if (hi_req[i]) begin
            hi_valid = 1'b1;
            hi_idx   = SEL_W'(i);
         end
      end
   end

   assign grant_valid = mode ? any_valid : ex_valid;
   assign grant       = mode ? (hi_valid ? hi_idx : lo_idx) : select;

   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_ready[i] = reset_n && grant_valid && can_accept && (grant == SEL_W'(i));
         if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign transfer = |in_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= '0;
      end else begin
         if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant;
            if (mode) begin
               rr_ptr <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_arb.sv
// Scoreboard bench for mux_n_arb: driver queues expected beats, monitor checks each accepted output beat.
module tb_mux_n_arb;
   localparam int W = 32;
   localparam int N = 8;
   localparam int S = 3;
   localparam int N6 = 6;

   typedef struct packed {
      logic [W-1:0] d;
      logic [S-1:0] c;
   } beat_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             reset_n;
   logic             mode;
   logic [S-1:0]     select;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [W-1:0]     out_data;
   logic [S-1:0]     out_chan;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     chdata [N];

   logic             mode6;
   logic [S-1:0]     select6;
   logic [N6*W-1:0]  in_data6;
   logic [N6-1:0]    in_valid6;
   logic [N6-1:0]    in_ready6;
   logic [W-1:0]     out_data6;
   logic [S-1:0]     out_chan6;
   logic             out_valid6;
   logic             out_ready6;

   int    checks = 0;
   int    errors = 0;
   beat_t expq[$];

   always_comb begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = chdata[i];
   end
   always_comb begin
      for (int i = 0; i < N6; i++) in_data6[i*W +: W] = 32'hC0DE_0000 + i;
   end

   mux_n_arb #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
      .clock(clock), .reset_n(reset_n), .mode(mode), .select(select),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_n_arb #(.WIDTH(W), .NUM_IN(N6), .SEL_W(S)) dut6 (
      .clock(clock), .reset_n(reset_n), .mode(mode6), .select(select6),
      .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
      .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(out_ready6)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One cycle: check in_ready at negedge, queue the expected beat, then step to just past posedge.
   task automatic cyc(input logic [N-1:0] exp_rdy, input bit push, input logic [S-1:0] ch);
      beat_t b;
      @(negedge clock);
      check("in_ready", in_ready, exp_rdy);
      if (push) begin
         b.d = chdata[ch];
         b.c = ch;
         expq.push_back(b);
      end
      @(posedge clock);
      #1;
   endtask

   // Monitor: a beat is consumed when out_valid && out_ready at the coming edge.
   always @(negedge clock) begin
      beat_t e;
      if (reset_n && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual_chan=%0d actual_data=%0h required=none", out_chan, out_data);
         end else begin
            e = expq.pop_front();
            check("beat_data", out_data, e.d);
            check("beat_chan", out_chan, e.c);
         end
      end
   end

   initial begin
      logic [W-1:0] frozen_d;
      reset_n = 1'b0; mode = 1'b1; select = '0; in_valid = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < N; i++) chdata[i] = 32'hA000_0000 + i;
      mode6 = 1'b0; select6 = '0; in_valid6 = '0; out_ready6 = 1'b1;

      // Reset and idle
      repeat (2) @(posedge clock);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_chan", out_chan, 0);
      check("rst_in_ready", in_ready, 0);
      in_valid = '0;
      reset_n  = 1'b1;
      cyc(8'h00, 0, 0);
      cyc(8'h00, 0, 0);
      check("idle_out_valid", out_valid, 0);

      // Explicit select stream
      mode = 1'b0; select = 3'd5; chdata[5] = 32'hDEAD_BEEF; in_valid = 8'hFF;
      cyc(8'h20, 1, 5);
      check("lat_out_valid", out_valid, 1);
      check("lat_out_data", out_data, 32'hDEAD_BEEF);
      check("lat_out_chan", out_chan, 5);
      repeat (3) cyc(8'h20, 1, 5);
      in_valid = '0;
      cyc(8'h00, 0, 0);
      check("drain_out_valid", out_valid, 0);

      // Round-robin fairness with wrap
      mode = 1'b1; in_valid = 8'hFF;
      for (int k = 0; k < 9; k++) cyc(8'(1 << (k % 8)), 1, 3'(k % 8));
      in_valid = '0;
      cyc(8'h00, 0, 0);
      check("rr_drain_valid", out_valid, 0);

      // Round-robin skip: bring pointer to 3, then 7,2,7, then drop 2
      in_valid = 8'h04;
      cyc(8'h04, 1, 2);
      in_valid = 8'h84;
      cyc(8'h80, 1, 7);
      cyc(8'h04, 1, 2);
      cyc(8'h80, 1, 7);
      in_valid = 8'h80;
      cyc(8'h80, 1, 7);

      // Mode 0 transfer must not move the pointer (still 0)
      mode = 1'b0; select = 3'd3; in_valid = 8'hFF;
      cyc(8'h08, 1, 3);
      mode = 1'b1;
      cyc(8'h01, 1, 0);

      // Backpressure: chan 0 beat held for 3 cycles while inputs move
      out_ready = 1'b0;
      frozen_d  = chdata[0];
      for (int k = 0; k < 3; k++) begin
         chdata[1] = 32'h1111_0000 + k;
         in_valid  = k[0] ? 8'h0F : 8'hF2;
         cyc(8'h00, 0, 0);
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, frozen_d);
         check("stall_chan", out_chan, 0);
      end
      out_ready = 1'b1; in_valid = 8'hFF;
      cyc(8'h02, 1, 1);
      check("nobubble_valid", out_valid, 1);
      check("nobubble_chan", out_chan, 1);

      // Reset mid-stall discards the held beat and the pointer
      out_ready = 1'b0;
      cyc(8'h00, 0, 0);
      reset_n = 1'b0;
      #1;
      check("rst2_out_valid", out_valid, 0);
      check("rst2_out_data", out_data, 0);
      check("rst2_out_chan", out_chan, 0);
      check("rst2_in_ready", in_ready, 0);
      expq.delete();
      @(posedge clock);
      #1;
      reset_n = 1'b1; out_ready = 1'b1;
      cyc(8'h01, 1, 0);
      in_valid = '0;
      cyc(8'h00, 0, 0);

      // NUM_IN=6: in-range beat, then out-of-range select
      in_valid6 = 6'h3F; select6 = 3'd4;
      @(negedge clock);
      check("n6_in_ready_sel4", in_ready6, 6'h10);
      @(posedge clock);
      #1;
      select6 = 3'd7;
      @(negedge clock);
      check("n6_in_ready_sel7", in_ready6, 0);
      check("n6_out_valid", out_valid6, 1);
      check("n6_out_data", out_data6, 32'hC0DE_0004);
      check("n6_out_chan", out_chan6, 4);
      @(posedge clock);
      #1;
      check("n6_drained", out_valid6, 0);
      @(negedge clock);
      check("n6_in_ready_idle", in_ready6, 0);
      check("n6_stays_idle", out_valid6, 0);

      // Bounded wait for all expected beats
      for (int k = 0; k < 10 && expq.size() != 0; k++) @(posedge clock);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL beats_outstanding actual=%0d required=0", expq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
